// File: rtl/rv32i_types_pkg.sv
// Shared types for the writeback stage: data word, register index,
// FIFO entry layout and the grant-source encoding.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;

  // Which producer owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_LSU  = 2'd1,
    WB_AU   = 2'd2,
    WB_MDU  = 2'd3
  } wb_src_t;

  // One queued AU result.
  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
  } wb_entry_t;

  // Round-robin memory between the AU side and the MDU.
  localparam logic LG_AU  = 1'b0;
  localparam logic LG_MDU = 1'b1;

  // A destination of x0 is never written, so such results are simply absorbed.
  function automatic logic is_x0(input reg_idx_t rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO holding AU results that lost arbitration. The head entry is
// presented combinationally so it can be granted in the same cycle it is
// at the front. Push and pop may occur together, including when full.
module wb_result_fifo
  import rv32i_types_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  wb_entry_t                i_push_entry,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  // A push into a full FIFO only lands when a pop frees the head slot.
  assign w_do_push = i_push && (!w_full || i_pop);
  assign w_do_pop  = i_pop && !w_empty;

  assign o_head  = r_mem[r_rptr];
  assign o_empty = w_empty;
  assign o_count = r_count;

  // Storage write; contents need no reset because pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_push_entry;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter. Merges the non-stallable AU result
// stream with LSU and MDU valid/ready streams onto one registered write
// port. LSU has fixed top priority; AU side and MDU alternate on ties.
module writeback_arbiter
  import rv32i_types_pkg::*;
#(
  parameter int unsigned AU_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        au_valid,
  input  logic [31:0] au_wdata,
  input  logic [4:0]  au_rd,
  output logic        au_full,
  output logic        au_overflow,
  input  logic        lsu_valid,
  input  logic [31:0] lsu_wdata,
  input  logic [4:0]  lsu_rd,
  output logic        lsu_ready,
  input  logic        mdu_valid,
  input  logic [31:0] mdu_wdata,
  input  logic [4:0]  mdu_rd,
  output logic        mdu_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam int unsigned CW = $clog2(AU_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(AU_DEPTH);

  // Output and state registers
  logic              r_rf_wen;
  reg_idx_t          r_rf_rd;
  word_t             r_rf_wdata;
  logic              r_overflow;
  logic              r_last_grant;

  // FIFO interface
  wb_entry_t         w_push_entry;
  wb_entry_t         w_head;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_pop;

  // Arbitration
  logic              w_au_live;
  logic              w_bypass;
  logic              w_au_req;
  logic              w_lsu_req;
  logic              w_mdu_req;
  wb_src_t           w_grant;
  reg_idx_t          w_sel_rd;
  word_t             w_sel_data;

  assign w_fifo_full = (w_fifo_count == FULL_CNT);

  // An AU result with a real destination; x0 results are silently absorbed.
  assign w_au_live = au_valid && !is_x0(au_rd);
  // Bypass only when nothing is queued, so FIFO order is never overtaken.
  assign w_bypass  = w_fifo_empty && w_au_live;
  assign w_au_req  = !w_fifo_empty || w_bypass;
  assign w_lsu_req = lsu_valid && !is_x0(lsu_rd);
  assign w_mdu_req = mdu_valid && !is_x0(mdu_rd);

  // Grant selection: LSU first, then round-robin between AU side and MDU.
  always_comb begin
    w_grant = WB_NONE;
    if (w_lsu_req) begin
      w_grant = WB_LSU;
    end else if (w_au_req && w_mdu_req) begin
      w_grant = (r_last_grant == LG_AU) ? WB_MDU : WB_AU;
    end else if (w_au_req) begin
      w_grant = WB_AU;
    end else if (w_mdu_req) begin
      w_grant = WB_MDU;
    end
  end

  // Handshake acceptance: granted, or an x0 destination that is dropped.
  assign lsu_ready = lsu_valid && (is_x0(lsu_rd) || (w_grant == WB_LSU));
  assign mdu_ready = mdu_valid && (is_x0(mdu_rd) || (w_grant == WB_MDU));

  // Queue the AU result unless it goes straight to the write port.
  assign w_push       = w_au_live && !((w_grant == WB_AU) && w_bypass);
  assign w_pop        = (w_grant == WB_AU) && !w_fifo_empty;
  assign w_push_entry = '{rd: au_rd, data: au_wdata};

  // Data selection for the write port according to the grant.
  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    unique case (w_grant)
      WB_LSU: begin
        w_sel_rd   = lsu_rd;
        w_sel_data = lsu_wdata;
      end
      WB_AU: begin
        w_sel_rd   = w_bypass ? au_rd    : w_head.rd;
        w_sel_data = w_bypass ? au_wdata : w_head.data;
      end
      WB_MDU: begin
        w_sel_rd   = mdu_rd;
        w_sel_data = mdu_wdata;
      end
      default: begin
        w_sel_rd   = '0;
        w_sel_data = '0;
      end
    endcase
  end

  wb_result_fifo #(
    .DEPTH (AU_DEPTH)
  ) u_fifo (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_empty      (w_fifo_empty),
    .o_count      (w_fifo_count)
  );

  // Registered write port; a grant in cycle t becomes one write pulse in t+1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rf_wen   <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_wen <= (w_grant != WB_NONE);
      if (w_grant != WB_NONE) begin
        r_rf_rd    <= w_sel_rd;
        r_rf_wdata <= w_sel_data;
      end
    end
  end

  // Round-robin memory; LSU grants leave it untouched. Resets to MDU so
  // the AU side wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_grant <= LG_MDU;
    end else if (w_grant == WB_AU) begin
      r_last_grant <= LG_AU;
    end else if (w_grant == WB_MDU) begin
      r_last_grant <= LG_MDU;
    end
  end

  // Sticky overflow: an AU result arrived with the FIFO full and no pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign au_full     = w_fifo_full;
  assign au_overflow = r_overflow;
  assign rf_wen      = r_rf_wen;
  assign rf_rd       = r_rf_rd;
  assign rf_wdata    = r_rf_wdata;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        au_valid;
  logic [31:0] au_wdata;
  logic [4:0]  au_rd;
  logic        au_full;
  logic        au_overflow;
  logic        lsu_valid;
  logic [31:0] lsu_wdata;
  logic [4:0]  lsu_rd;
  logic        lsu_ready;
  logic        mdu_valid;
  logic [31:0] mdu_wdata;
  logic [4:0]  mdu_rd;
  logic        mdu_ready;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  writeback_arbiter #(.AU_DEPTH(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .au_valid    (au_valid),
    .au_wdata    (au_wdata),
    .au_rd       (au_rd),
    .au_full     (au_full),
    .au_overflow (au_overflow),
    .lsu_valid   (lsu_valid),
    .lsu_wdata   (lsu_wdata),
    .lsu_rd      (lsu_rd),
    .lsu_ready   (lsu_ready),
    .mdu_valid   (mdu_valid),
    .mdu_wdata   (mdu_wdata),
    .mdu_rd      (mdu_rd),
    .mdu_ready   (mdu_ready),
    .rf_wen      (rf_wen),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    au_valid = 1'b0; au_wdata = '0; au_rd = '0;
    lsu_valid = 1'b0; lsu_wdata = '0; lsu_rd = '0;
    mdu_valid = 1'b0; mdu_wdata = '0; mdu_rd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL reset_rf_wen got=%0b exp=0", rf_wen); end
    checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL reset_rf_rd got=%0d exp=0", rf_rd); end
    checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_rf_wdata got=%08h exp=0", rf_wdata); end
    checks++; if (au_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", au_overflow); end
    checks++; if (au_full !== 1'b0) begin failures++; $display("FAIL reset_au_full got=%0b exp=0", au_full); end
    $display("reset: rf_wen=%0b rf_rd=%0d au_full=%0b", rf_wen, rf_rd, au_full);
  endtask

  task automatic test_au_bypass();
    au_valid = 1'b1; au_rd = 5'd5; au_wdata = 32'h0000_1234;
    cyc();
    idle_inputs();
    checks++; if (rf_wen !== 1'b1) begin failures++; $display("FAIL bypass_wen got=%0b exp=1", rf_wen); end
    checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL bypass_rd got=%0d exp=5", rf_rd); end
    checks++; if (rf_wdata !== 32'h0000_1234) begin failures++; $display("FAIL bypass_data got=%08h exp=00001234", rf_wdata); end
    checks++; if (au_full !== 1'b0) begin failures++; $display("FAIL bypass_full got=%0b exp=0", au_full); end
    cyc();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL bypass_no_extra got=%0b exp=0", rf_wen); end
    $display("au_bypass: rd=5 data=00001234 written next cycle");
  endtask

  task automatic test_lsu_priority();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wdata = 32'hAAAA_0000;
    au_valid = 1'b1; au_rd = 5'd4; au_wdata = 32'h0000_0011;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL lsu_pri_ready got=%0b exp=1", lsu_ready); end
    cyc();
    idle_inputs();
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'hAAAA_0000) begin failures++; $display("FAIL lsu_pri_first got=%0b/%0d/%08h exp=1/3/aaaa0000", rf_wen, rf_rd, rf_wdata); end
    cyc();
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h0000_0011) begin failures++; $display("FAIL lsu_pri_second got=%0b/%0d/%08h exp=1/4/00000011", rf_wen, rf_rd, rf_wdata); end
    cyc();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL lsu_pri_idle got=%0b exp=0", rf_wen); end
    $display("lsu_priority: writes rd=3 then rd=4");
  endtask

  task automatic test_round_robin();
    do_reset();
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wdata = 32'h0000_0077;
    au_valid = 1'b1; au_rd = 5'd8; au_wdata = 32'h0000_0088;
    #1;
    checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL rr_mdu_ready_t0 got=%0b exp=0", mdu_ready); end
    cyc();
    au_rd = 5'd9; au_wdata = 32'h0000_0099;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL rr_mdu_ready_t1 got=%0b exp=1", mdu_ready); end
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd8) begin failures++; $display("FAIL rr_first got=%0b/%0d exp=1/8", rf_wen, rf_rd); end
    cyc();
    idle_inputs();
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h0000_0077) begin failures++; $display("FAIL rr_second got=%0b/%0d/%08h exp=1/7/00000077", rf_wen, rf_rd, rf_wdata); end
    cyc();
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h0000_0099) begin failures++; $display("FAIL rr_third got=%0b/%0d/%08h exp=1/9/00000099", rf_wen, rf_rd, rf_wdata); end
    cyc();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL rr_idle got=%0b exp=0", rf_wen); end
    $display("round_robin: write order 8,7,9");
  endtask

  task automatic test_x0_discard();
    au_valid = 1'b1; au_rd = 5'd0; au_wdata = 32'hDEAD_BEEF;
    cyc();
    idle_inputs();
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_wdata = 32'hCAFE_F00D;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL x0_mdu_ready got=%0b exp=1", mdu_ready); end
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL x0_au_wen got=%0b exp=0", rf_wen); end
    cyc();
    idle_inputs();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL x0_mdu_wen got=%0b exp=0", rf_wen); end
    // FIFO must still be empty: a fresh AU result bypasses immediately.
    au_valid = 1'b1; au_rd = 5'd6; au_wdata = 32'h0000_0066;
    cyc();
    idle_inputs();
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd6 || rf_wdata !== 32'h0000_0066) begin failures++; $display("FAIL x0_after_bypass got=%0b/%0d/%08h exp=1/6/00000066", rf_wen, rf_rd, rf_wdata); end
    cyc();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL x0_idle got=%0b exp=0", rf_wen); end
    $display("x0_discard: no writes for rd=0, fifo empty");
  endtask

  task automatic test_full_overflow();
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wdata = 32'h0000_0A0A;
    au_valid = 1'b1; au_rd = 5'd1; au_wdata = 32'h0000_0001;
    cyc();
    checks++; if (au_full !== 1'b0) begin failures++; $display("FAIL ovf_full_after1 got=%0b exp=0", au_full); end
    au_rd = 5'd2; au_wdata = 32'h0000_0002;
    cyc();
    checks++; if (au_full !== 1'b1) begin failures++; $display("FAIL ovf_full_after2 got=%0b exp=1", au_full); end
    checks++; if (au_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", au_overflow); end
    au_rd = 5'd3; au_wdata = 32'h0000_0003;
    cyc();
    idle_inputs();
    checks++; if (au_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", au_overflow); end
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd10) begin failures++; $display("FAIL ovf_lsu_write got=%0b/%0d exp=1/10", rf_wen, rf_rd); end
    cyc();
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd1 || rf_wdata !== 32'h0000_0001) begin failures++; $display("FAIL ovf_drain1 got=%0b/%0d/%08h exp=1/1/00000001", rf_wen, rf_rd, rf_wdata); end
    checks++; if (au_full !== 1'b0) begin failures++; $display("FAIL ovf_full_drain got=%0b exp=0", au_full); end
    cyc();
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h0000_0002) begin failures++; $display("FAIL ovf_drain2 got=%0b/%0d/%08h exp=1/2/00000002", rf_wen, rf_rd, rf_wdata); end
    cyc();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL ovf_dropped_third got=%0b/%0d exp=0", rf_wen, rf_rd); end
    checks++; if (au_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", au_overflow); end
    $display("full_overflow: rd=3 dropped, overflow sticky, writes 1,2");
  endtask

  task automatic test_reset_mid_flight();
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_wdata = 32'h0000_0B0B;
    au_valid = 1'b1; au_rd = 5'd12; au_wdata = 32'h0000_000C;
    cyc();
    au_rd = 5'd13; au_wdata = 32'h0000_000D;
    cyc();
    checks++; if (au_full !== 1'b1) begin failures++; $display("FAIL rmf_full_before got=%0b exp=1", au_full); end
    idle_inputs();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL rmf_wen_suppressed got=%0b exp=0", rf_wen); end
    checks++; if (au_full !== 1'b0) begin failures++; $display("FAIL rmf_full_after got=%0b exp=0", au_full); end
    checks++; if (au_overflow !== 1'b0) begin failures++; $display("FAIL rmf_overflow_cleared got=%0b exp=0", au_overflow); end
    au_valid = 1'b1; au_rd = 5'd14; au_wdata = 32'h0000_000E;
    cyc();
    idle_inputs();
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd14 || rf_wdata !== 32'h0000_000E) begin failures++; $display("FAIL rmf_bypass got=%0b/%0d/%08h exp=1/14/0000000e", rf_wen, rf_rd, rf_wdata); end
    cyc();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL rmf_no_stale got=%0b/%0d exp=0", rf_wen, rf_rd); end
    $display("reset_mid_flight: queue discarded, rd=14 bypassed");
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    test_reset();
    test_au_bypass();
    test_lsu_priority();
    test_round_robin();
    test_x0_discard();
    test_full_overflow();
    test_reset_mid_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
